// File: rtl/vb_requant.sv
// vb_requant: requantises chunked NBits signed lanes to OutBits.
// Each lane gets an arithmetic rounding right-shift (half toward +inf) and then
// signed saturation. The datapath is a 2-stage pipeline with backpressure.
// The block frames chunks into vectors and raises a per-vector saturation flag.
// Optional feature: define VB_REQUANT_RELU_EN to fuse a ReLU after rounding.
module vb_requant #(
   parameter int unsigned InVecLength = 16,
   parameter int unsigned WorkingRegs = 4,
   parameter int unsigned NBits       = 16,
   parameter int unsigned OutBits     = 8,
   parameter int unsigned Shift       = 4
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           in_data_valid,
   input  logic [WorkingRegs*NBits-1:0]   in_data,
   output logic                           req_chunk_in,
   input  logic                           out_ready,
   output logic [WorkingRegs*OutBits-1:0] write_out_data,
   output logic                           out_chunk_valid,
   output logic                           out_vector_valid,
   output logic                           out_sat_flag
);

   localparam int unsigned ChunksPerVec = InVecLength / WorkingRegs;
   // Rounded value is kept one bit wider than the input so x + half never wraps
   localparam int unsigned RW   = NBits + 1;
   localparam int unsigned CntW = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(ChunksPerVec - 1);
   // Half-LSB rounding constant; zero when no shift is applied
   localparam logic signed [RW-1:0] RoundAdd =
      (Shift == 0) ? '0 : RW'(64'd1 << (Shift - 1));
   localparam logic signed [RW-1:0] SatMax = RW'((64'd1 << (OutBits - 1)) - 64'd1);
   localparam logic signed [RW-1:0] SatMin = ~SatMax;

   // Elaboration-time parameter sanity
   if ((InVecLength % WorkingRegs) != 0) begin : g_len_chk
      $error("vb_requant: InVecLength must be a multiple of WorkingRegs");
   end
   if (OutBits > NBits) begin : g_width_chk
      $error("vb_requant: OutBits must not exceed NBits");
   end
   if (Shift >= NBits) begin : g_shift_chk
      $error("vb_requant: Shift must be below NBits");
   end

   logic                           stall;
   logic                           accept;
   logic                           xfer;
   logic                           last_c;
   logic                           s1_valid;
   logic                           s2_valid;
   logic signed [RW-1:0]           rnd_c [WorkingRegs];
   logic signed [RW-1:0]           s1_r  [WorkingRegs];
   logic [WorkingRegs*OutBits-1:0] clamp_c;
   logic [WorkingRegs*OutBits-1:0] s2_data;
   logic [WorkingRegs-1:0]         sat_c;
   logic [WorkingRegs-1:0]         s2_sat;
   logic [CntW-1:0]                cnt;
   logic                           sat_acc;

   // Handshake: a full, unaccepted output stage freezes the whole pipe
   assign stall  = s2_valid & ~out_ready;
   assign accept = in_data_valid & ~stall;
   assign xfer   = s2_valid & out_ready;
   assign last_c = (cnt == LastCnt);

   // Stage-1 combinational: sign-extend, add half LSB, arithmetic shift
   always_comb begin
      for (int i = 0; i < int'(WorkingRegs); i++) begin
         rnd_c[i] = ($signed({in_data[i*NBits + NBits - 1], in_data[i*NBits +: NBits]})
                     + RoundAdd) >>> Shift;
      end
   end

   // Stage-2 combinational: optional ReLU, then clamp to the OutBits range
   always_comb begin : p_clamp
      logic signed [RW-1:0] v;
      clamp_c = '0;
      sat_c   = '0;
      v       = '0;
      for (int i = 0; i < int'(WorkingRegs); i++) begin
         v = s1_r[i];
`ifdef VB_REQUANT_RELU_EN
         if (v[RW-1]) begin
            v = '0;
         end
`endif
         if (v > SatMax) begin
            clamp_c[i*OutBits +: OutBits] = SatMax[OutBits-1:0];
            sat_c[i]                      = 1'b1;
         end else if (v < SatMin) begin
            clamp_c[i*OutBits +: OutBits] = SatMin[OutBits-1:0];
            sat_c[i]                      = 1'b1;
         end else begin
            clamp_c[i*OutBits +: OutBits] = v[OutBits-1:0];
         end
      end
   end

   // Pipeline registers: both stages advance together unless stalled
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_sat   <= '0;
         for (int i = 0; i < int'(WorkingRegs); i++) begin
            s1_r[i] <= '0;
         end
      end else if (!stall) begin
         s1_valid <= accept;
         if (accept) begin
            s1_r <= rnd_c;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= clamp_c;
            s2_sat  <= sat_c;
         end
      end
   end

   // Vector framing: chunk position and sticky saturation across the vector
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt     <= '0;
         sat_acc <= 1'b0;
      end else if (xfer) begin
         if (last_c) begin
            cnt     <= '0;
            sat_acc <= 1'b0;
         end else begin
            cnt     <= cnt + CntW'(1);
            sat_acc <= sat_acc | (|s2_sat);
         end
      end
   end

   assign req_chunk_in     = ~stall;
   assign out_chunk_valid  = s2_valid;
   assign write_out_data   = s2_data;
   assign out_vector_valid = s2_valid & last_c;
   assign out_sat_flag     = out_vector_valid & (sat_acc | (|s2_sat));

endmodule
